// File: rtl/bank_write_sequencer.sv
// rtl/bank_write_sequencer.sv - skewed bank write sequencer with ping-pong block buffers
module bank_write_sequencer #(
  parameter int BANK_COUNT  = 3,
  parameter int BLOCK_DEPTH = 480,
  parameter int DATA_WIDTH  = 8,
  localparam int AW = $clog2(BLOCK_DEPTH)
) (
  input  logic                                   I_clk,
  input  logic                                   I_rst,
  input  logic                                   I_line_start,
  input  logic                                   I_valid,
  input  logic [0:BANK_COUNT-1][DATA_WIDTH-1:0]  I_pixel,
  output logic                                   O_ready,
  output logic [BANK_COUNT-1:0]                  O_bank_we,
  output logic [0:BANK_COUNT-1][AW:0]            O_bank_addr,
  output logic [0:BANK_COUNT-1][DATA_WIDTH-1:0]  O_bank_data,
  output logic                                   O_block_valid,
  output logic                                   O_block_index,
  input  logic                                   I_block_release,
  output logic                                   O_drop
);

  localparam int OW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

  state_t                                state_q, state_d;
  logic                                  wr_buf_q, wr_buf_d;
  logic [AW-1:0]                         count_q, count_d;
  logic [OW-1:0]                         off_q, off_d;
  logic [AW-1:0]                         base_q, base_d;
  logic [1:0]                            full_q, full_d;
  logic                                  rd_idx_q, rd_idx_d;
  logic                                  valid_q, valid_d;
  logic                                  drop_q, drop_d;
  logic [BANK_COUNT-1:0]                 we_q, we_d;
  logic [0:BANK_COUNT-1][AW:0]           addr_q, addr_d;
  logic [0:BANK_COUNT-1][DATA_WIDTH-1:0] data_q, data_d;

  logic          restart, write, release_ok;
  logic [AW-1:0] g_cnt, g_base;
  logic [OW-1:0] g_off, c_sel;
  int            c, a;

  assign O_ready = (state_q != STALL);

  always_comb begin
    state_d  = state_q;
    wr_buf_d = wr_buf_q;
    count_d  = count_q;
    off_d    = off_q;
    base_d   = base_q;
    full_d   = full_q;
    rd_idx_d = rd_idx_q;
    drop_d   = 1'b0;
    we_d     = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    c        = 0;
    a        = 0;
    c_sel    = '0;

    // A line start rewinds the pixel position before the same-cycle pixel is placed
    restart    = I_line_start && (state_q != STALL);
    g_cnt      = restart ? '0 : count_q;
    g_off      = restart ? '0 : off_q;
    g_base     = restart ? '0 : base_q;
    write      = I_valid && ((state_q == FILL) || (state_q == IDLE && I_line_start));
    release_ok = I_block_release && valid_q;

    if (release_ok) begin
      full_d[rd_idx_q] = 1'b0;
      rd_idx_d         = ~rd_idx_q;
    end
    // Valid follows the full flags one cycle late, but tracks a release immediately
    valid_d = release_ok ? full_q[~rd_idx_q] : full_q[rd_idx_q];

    if (state_q == IDLE && I_line_start) begin
      state_d = FILL;
    end
    if (state_q == FILL && I_line_start) begin
      drop_d  = (count_q != '0);
      count_d = '0;
      off_d   = '0;
      base_d  = '0;
    end

    if (write) begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        c = b + BANK_COUNT - int'(g_off);
        if (c >= BANK_COUNT) c = c - BANK_COUNT;
        a         = int'(g_base) + c;
        c_sel     = c[OW-1:0];
        we_d[b]   = (a < BLOCK_DEPTH);
        addr_d[b] = {wr_buf_q, a[AW-1:0]};
        data_d[b] = I_pixel[c_sel];
      end
      if (g_cnt == AW'(BLOCK_DEPTH - 1)) begin
        full_d[wr_buf_q] = 1'b1;
        wr_buf_d         = ~wr_buf_q;
        count_d          = '0;
        off_d            = '0;
        base_d           = '0;
        state_d          = full_d[~wr_buf_q] ? STALL : FILL;
      end else begin
        count_d = g_cnt + 1'b1;
        if (g_off == OW'(BANK_COUNT - 1)) begin
          off_d  = '0;
          base_d = g_base + AW'(BANK_COUNT);
        end else begin
          off_d  = g_off + 1'b1;
          base_d = g_base;
        end
      end
    end

    if (state_q == STALL && !full_d[wr_buf_q]) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q  <= IDLE;
      wr_buf_q <= 1'b0;
      count_q  <= '0;
      off_q    <= '0;
      base_q   <= '0;
      full_q   <= '0;
      rd_idx_q <= 1'b0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_buf_q <= wr_buf_d;
      count_q  <= count_d;
      off_q    <= off_d;
      base_q   <= base_d;
      full_q   <= full_d;
      rd_idx_q <= rd_idx_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign O_bank_we     = we_q;
  assign O_bank_addr   = addr_q;
  assign O_bank_data   = data_q;
  assign O_block_valid = valid_q;
  assign O_block_index = rd_idx_q;
  assign O_drop        = drop_q;

endmodule
